muldiv_unit: RTL

//  Iterative multiply/divide responder for the execute stage. The single-cycle

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, sign fix-up, valid/ready I/O.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] s,
    input  logic [N-1:0] t,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [N-1:0]  wh;
    logic [N-1:0]  wl;
    logic [N-1:0]  wt;
    logic          is_div;
    logic          neg_q;
    logic          neg_r;

    logic          accept;
    logic          op_signed;
    logic          op_div;
    logic          t_zero;
    logic          last;
    logic [N-1:0]  s_mag;
    logic [N-1:0]  t_mag;

    logic [N:0]     mul_sum;
    logic [N:0]     div_sh;
    logic [N:0]     div_diff;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   res_hi;
    logic [N-1:0]   res_lo;

    assign op_signed = ~req_op[0];
    assign op_div    = req_op[1];
    assign t_zero    = (t == '0);
    assign accept    = req_valid & req_ready;
    assign last      = (cnt == CW'(N - 1));
    assign s_mag     = (op_signed && s[N-1]) ? -s : s;
    assign t_mag     = (op_signed && t[N-1]) ? -t : t;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs; flush beats resp_ready.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = ~flush;
                if (req_valid && !flush) begin
                    state_nx = (op_div && t_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = flush ? IDLE : DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One iteration step for multiply and divide.
    always_comb begin
        mul_sum  = {1'b0, wh} + (wl[0] ? {1'b0, wt} : '0);
        div_sh   = {wh, wl[N-1]};
        div_diff = div_sh - {1'b0, wt};
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod     = {wh, wl};
        prod_fix = neg_q ? -prod : prod;
        res_hi   = prod_fix[2*N-1:N];
        res_lo   = prod_fix[N-1:0];
        if (is_div) begin
            res_lo = neg_q ? -wl : wl;
            res_hi = neg_r ? -wh : wh;
        end
    end

    // Working registers and architectural hi/lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            wh          <= '0;
            wl          <= '0;
            wt          <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            wh     <= '0;
            wl     <= s_mag;
            wt     <= t_mag;
            is_div <= op_div;
            neg_q  <= op_signed & (s[N-1] ^ t[N-1]);
            neg_r  <= op_signed & s[N-1];
            if (op_div && t_zero) begin
                hi          <= '0;
                lo          <= '0;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN && !flush) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                if (!div_diff[N]) begin
                    wh <= div_diff[N-1:0];
                    wl <= {wl[N-2:0], 1'b1};
                end else begin
                    wh <= div_sh[N-1:0];
                    wl <= {wl[N-2:0], 1'b0};
                end
            end else begin
                wh <= mul_sum[N:1];
                wl <= {mul_sum[0], wl[N-1:1]};
            end
        end else if (state == FIX && !flush) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= 1'b0;
        end
    end

endmodule
